l1a_dav_scheduler: RTL and testbench

L1A_DAV_SCHEDULER -- requirements
Module: l1a_dav_scheduler

---
 rtl/l1a_dav_scheduler.sv | 248 ++++++++++++++++++++++++
 tb/tb_l1a_dav_scheduler.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/l1a_dav_scheduler.sv
// Queues L1A triggers, collects ALCT/TMB data-available pulses per head event, emits one record per L1A.
// Record valid one cycle after the last DAV or window expiry; holds until evt_ready, queue absorbs DEPTH L1As.

module l1a_dav_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 8,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push_vld,
  input  logic [WIDTH-1:0] i_push_dat,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head_dat,
  output logic             o_full,
  output logic             o_empty,
  output logic [AW:0]      o_cnt
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [AW:0]      r_cnt;
  logic             w_push;
  logic             w_pop;

  assign o_full     = (r_cnt == (AW+1)'(DEPTH));
  assign o_empty    = (r_cnt == '0);
  assign o_cnt      = r_cnt;
  assign o_head_dat = r_mem[r_rd];
  assign w_push     = i_push_vld & ~o_full;
  assign w_pop      = i_pop & ~o_empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_push_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

module l1a_dav_scheduler #(
  parameter int DEPTH   = 8,
  parameter int DAV_WIN = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        l1a,
  input  logic [7:0]  lct,
  input  logic        alct_dav,
  input  logic        tmb_dav,
  output logic        evt_valid,
  input  logic        evt_ready,
  output logic [23:0] evt_l1a_cnt,
  output logic [7:0]  evt_lct,
  output logic        evt_alct,
  output logic        evt_tmb,
  output logic        evt_timeout,
  output logic        overflow,
  output logic [7:0]  orphan_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [23:0] cnt;
    logic [7:0]  lct;
    logic [15:0] ts;
  } entry_t;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_EMIT} state_t;

  state_t      r_state;
  state_t      w_state_nx;
  logic [15:0] r_ts;
  logic [23:0] r_l1a_cnt;
  logic        r_alct;
  logic        r_tmb;
  logic        r_overflow;
  logic [7:0]  r_orphan;
  logic [23:0] r_evt_cnt;
  logic [7:0]  r_evt_lct;
  logic        r_evt_alct;
  logic        r_evt_tmb;
  logic        r_evt_timeout;

  logic        w_l1a;
  logic        w_alct;
  logic        w_tmb;
  logic        w_push;
  logic        w_pop;
  logic        w_full;
  logic        w_empty;
  logic [AW:0] w_cnt;
  entry_t      w_push_dat;
  entry_t      w_head;
  logic [15:0] w_age;
  logic        w_expired;
  logic        w_alct_nx;
  logic        w_tmb_nx;
  logic        w_both;
  logic        w_load;
  logic        w_timeout;
  logic        w_orph_a;
  logic        w_orph_t;
  logic [8:0]  w_orph_sum;

  assign w_l1a  = en & l1a;
  assign w_alct = en & alct_dav;
  assign w_tmb  = en & tmb_dav;
  assign w_push = w_l1a & ~w_full;
  assign w_pop  = (r_state == S_EMIT) & evt_ready;

  assign w_push_dat = '{cnt: r_l1a_cnt + 24'd1, lct: lct, ts: r_ts};

  l1a_dav_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push_vld (w_push),
    .i_push_dat (w_push_dat),
    .i_pop      (w_pop),
    .o_head_dat (w_head),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_cnt      (w_cnt)
  );

  // Age is modular so the window survives the 16-bit timestamp wrap.
  assign w_age     = r_ts - w_head.ts;
  assign w_expired = ({1'b0, w_age} >= 17'(DAV_WIN));
  assign w_alct_nx = r_alct | w_alct;
  assign w_tmb_nx  = r_tmb | w_tmb;
  assign w_both    = w_alct_nx & w_tmb_nx;

  always_comb begin
    w_state_nx = r_state;
    w_load     = 1'b0;
    w_timeout  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty || w_push) w_state_nx = S_WAIT;
      end
      S_WAIT: begin
        if (w_both) begin
          w_state_nx = S_EMIT;
          w_load     = 1'b1;
        end else if (w_expired) begin
          w_state_nx = S_EMIT;
          w_load     = 1'b1;
          w_timeout  = 1'b1;
        end
      end
      S_EMIT: begin
        if (evt_ready) begin
          if ((w_cnt > (AW+1)'(1)) || w_push) w_state_nx = S_WAIT;
          else                                w_state_nx = S_IDLE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ts       <= '0;
      r_l1a_cnt  <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_ts <= r_ts + 16'd1;
      if (w_l1a)          r_l1a_cnt  <= r_l1a_cnt + 24'd1;
      if (w_l1a & w_full) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alct <= 1'b0;
      r_tmb  <= 1'b0;
    end else if (w_pop) begin
      r_alct <= 1'b0;
      r_tmb  <= 1'b0;
    end else if (r_state == S_WAIT) begin
      r_alct <= w_alct_nx;
      r_tmb  <= w_tmb_nx;
    end
  end

  // A DAV with no head waiting for it, or a repeat for the same head, is unattributed.
  assign w_orph_a   = w_alct & ((r_state != S_WAIT) | r_alct);
  assign w_orph_t   = w_tmb  & ((r_state != S_WAIT) | r_tmb);
  assign w_orph_sum = {1'b0, r_orphan} + {8'd0, w_orph_a} + {8'd0, w_orph_t};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 r_orphan <= '0;
    else if (w_orph_sum > 9'd255) r_orphan <= 8'd255;
    else                        r_orphan <= w_orph_sum[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_evt_cnt     <= '0;
      r_evt_lct     <= '0;
      r_evt_alct    <= 1'b0;
      r_evt_tmb     <= 1'b0;
      r_evt_timeout <= 1'b0;
    end else if (w_load) begin
      r_evt_cnt     <= w_head.cnt;
      r_evt_lct     <= w_head.lct;
      r_evt_alct    <= w_alct_nx;
      r_evt_tmb     <= w_tmb_nx;
      r_evt_timeout <= w_timeout;
    end
  end

  assign evt_valid   = (r_state == S_EMIT);
  assign evt_l1a_cnt = r_evt_cnt;
  assign evt_lct     = r_evt_lct;
  assign evt_alct    = r_evt_alct;
  assign evt_tmb     = r_evt_tmb;
  assign evt_timeout = r_evt_timeout;
  assign overflow    = r_overflow;
  assign orphan_cnt  = r_orphan;

endmodule

// File: tb/tb_l1a_dav_scheduler.sv
// Scoreboard bench for l1a_dav_scheduler: directed L1A/DAV sequences, monitor checks every handshaken record.

module tb_l1a_dav_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        l1a = 1'b0;
  logic [7:0]  lct = 8'd0;
  logic        alct_dav = 1'b0;
  logic        tmb_dav = 1'b0;
  logic        evt_ready = 1'b0;
  logic        evt_valid;
  logic [23:0] evt_l1a_cnt;
  logic [7:0]  evt_lct;
  logic        evt_alct;
  logic        evt_tmb;
  logic        evt_timeout;
  logic        overflow;
  logic [7:0]  orphan_cnt;

  l1a_dav_scheduler #(.DEPTH(8), .DAV_WIN(64)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .l1a         (l1a),
    .lct         (lct),
    .alct_dav    (alct_dav),
    .tmb_dav     (tmb_dav),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .evt_l1a_cnt (evt_l1a_cnt),
    .evt_lct     (evt_lct),
    .evt_alct    (evt_alct),
    .evt_tmb     (evt_tmb),
    .evt_timeout (evt_timeout),
    .overflow    (overflow),
    .orphan_cnt  (orphan_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    int cnt;
    int lct;
    int a;
    int t;
    int to;
    int vcyc;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string name, input int act, input int exp_v);
    n_chk++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  function automatic exp_t mk(input int c, input int l, input int a, input int t, input int to, input int vc);
    exp_t e;
    e.cnt = c; e.lct = l; e.a = a; e.t = t; e.to = to; e.vcyc = vc;
    return e;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin : mon
    int vrise;
    exp_t e;
    vrise = -1;
    forever begin
      @(negedge clk);
      if (!rst_n || !evt_valid) begin
        vrise = -1;
      end else begin
        if (vrise < 0) vrise = cyc;
        if (evt_ready) begin
          if (sb.size() == 0) begin
            chk("unexpected_record", int'(evt_l1a_cnt), -1);
          end else begin
            e = sb.pop_front();
            chk("rec_cnt", int'(evt_l1a_cnt), e.cnt);
            chk("rec_lct", int'(evt_lct), e.lct);
            chk("rec_alct", int'(evt_alct), e.a);
            chk("rec_tmb", int'(evt_tmb), e.t);
            chk("rec_timeout", int'(evt_timeout), e.to);
            if (e.vcyc >= 0) chk("rec_valid_cycle", vrise, e.vcyc);
          end
          vrise = -1;
        end
      end
    end
  end

  initial begin : stim
    int t;
    int r;
    tick(2);
    chk("rst_evt_valid", int'(evt_valid), 0);
    chk("rst_evt_cnt", int'(evt_l1a_cnt), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_orphan", int'(orphan_cnt), 0);
    rst_n = 1'b1;
    en = 1'b1;
    tick(2);

    // Overflow: nine back-to-back L1As into an 8-deep queue, downstream stalled.
    evt_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      l1a = 1'b1;
      lct = 8'(16 + i);
      if (i < 8) sb.push_back(mk(i + 1, 16 + i, 0, 0, 1, -1));
      if (i == 8) chk("overflow_before_drop", int'(overflow), 0);
      tick(1);
    end
    l1a = 1'b0;
    lct = 8'd0;
    chk("overflow_set", int'(overflow), 1);
    tick(76);
    evt_ready = 1'b1;
    tick(30);
    chk("overflow_sticky", int'(overflow), 1);

    // Inputs ignored while disabled.
    en = 1'b0;
    l1a = 1'b1;
    alct_dav = 1'b1;
    tick(1);
    l1a = 1'b0;
    alct_dav = 1'b0;
    en = 1'b1;
    tick(2);
    chk("orphan_en_low", int'(orphan_cnt), 0);

    // Both DAVs collected; cnt continues from the dropped ninth L1A.
    t = cyc;
    sb.push_back(mk(10, 'hA5, 1, 1, 0, t + 6));
    l1a = 1'b1; lct = 8'hA5;
    tick(1);
    l1a = 1'b0; lct = 8'd0;
    tick(2);
    alct_dav = 1'b1;
    tick(1);
    alct_dav = 1'b0;
    tick(1);
    tmb_dav = 1'b1;
    tick(1);
    tmb_dav = 1'b0;
    tick(4);
    chk("orphan_after_pair", int'(orphan_cnt), 0);

    // No DAVs: window expiry.
    t = cyc;
    sb.push_back(mk(11, 'h3C, 0, 0, 1, t + 65));
    l1a = 1'b1; lct = 8'h3C;
    tick(1);
    l1a = 1'b0; lct = 8'd0;
    tick(70);

    // Orphans: DAV on empty queue, then a duplicate ALCT while waiting.
    alct_dav = 1'b1;
    tick(1);
    alct_dav = 1'b0;
    tick(1);
    chk("orphan_empty_q", int'(orphan_cnt), 1);
    t = cyc;
    sb.push_back(mk(12, 'h11, 1, 1, 0, t + 5));
    l1a = 1'b1; lct = 8'h11;
    tick(1);
    l1a = 1'b0; lct = 8'd0;
    tick(1);
    alct_dav = 1'b1;
    tick(2);
    alct_dav = 1'b0;
    tmb_dav = 1'b1;
    tick(1);
    tmb_dav = 1'b0;
    tick(3);
    chk("orphan_duplicate", int'(orphan_cnt), 2);

    // Stalled record holds steady, then reset discards it immediately.
    evt_ready = 1'b0;
    l1a = 1'b1; lct = 8'h77;
    tick(1);
    l1a = 1'b0; lct = 8'd0;
    alct_dav = 1'b1; tmb_dav = 1'b1;
    tick(1);
    alct_dav = 1'b0; tmb_dav = 1'b0;
    for (int k = 0; k < 10; k++) begin
      chk("hold_valid", int'(evt_valid), 1);
      chk("hold_cnt", int'(evt_l1a_cnt), 13);
      chk("hold_lct", int'(evt_lct), 'h77);
      chk("hold_flags", int'({evt_alct, evt_tmb, evt_timeout}), 'b110);
      tick(1);
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_evt_valid", int'(evt_valid), 0);
    chk("arst_evt_cnt", int'(evt_l1a_cnt), 0);
    chk("arst_evt_lct", int'(evt_lct), 0);
    chk("arst_overflow", int'(overflow), 0);
    chk("arst_orphan", int'(orphan_cnt), 0);
    tick(2);
    rst_n = 1'b1;
    r = cyc;
    evt_ready = 1'b1;
    tick(3);
    chk("post_rst_no_record", int'(evt_valid), 0);

    // Timestamp wrap: L1A at ts=0xFFF0 expires at ts=0x0030; numbering restarts at 1.
    while (cyc < r + 32'hFFF0) tick(1);
    t = cyc;
    sb.push_back(mk(1, 'h5A, 0, 0, 1, t + 65));
    l1a = 1'b1; lct = 8'h5A;
    tick(1);
    l1a = 1'b0; lct = 8'd0;
    tick(70);

    chk("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
